// File: rtl/instr_inject_pkg.sv
// Shared types and constants for the instruction-injection front end.
// Saturating counter helper lives here so every counter uses the same rule.
package instr_inject_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam logic [3:0]  HLT_OPC     = 4'hF;
  localparam int          CNT_W       = 16;
  localparam logic [15:0] NOP_DEFAULT = 16'h0000;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module instr_fifo
  import instr_inject_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/instr_inject_queue.sv
// Instruction-injection front end: queues host-written words and feeds the cpu
// one per cycle, filling underruns with NOPs, stopping on hlt or watchdog expiry.
module instr_inject_queue
  import instr_inject_pkg::*;
#(
  parameter int                  INSTR_W    = 16,
  parameter int                  PC_W       = 16,
  parameter int                  DEPTH      = 16,
  parameter int                  MAX_CYCLES = 100000,
  parameter logic [INSTR_W-1:0]  NOP_INSTR  = NOP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [INSTR_W-1:0]     wr_instr,
  input  logic                   start,
  input  logic [PC_W-1:0]        cpu_pc,
  input  logic                   cpu_hlt,
  output logic [INSTR_W-1:0]     cpu_instr,
  output logic                   cpu_mode,
  output logic                   issue,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic                   timeout,
  output logic                   overflow,
  output logic [CNT_W-1:0]       underrun_cnt,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic [PC_W-1:0]        last_pc
);

  localparam int              WD_W    = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  state_t               state_q, state_d;
  logic [WD_W-1:0]      cyc_q, cyc_d;
  logic [INSTR_W-1:0]   cpu_instr_q, cpu_instr_d;
  logic                 cpu_mode_q, cpu_mode_d;
  logic                 issue_q, issue_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     underrun_q, underrun_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [PC_W-1:0]      last_pc_q, last_pc_d;

  logic [INSTR_W-1:0]   fifo_head_s;
  logic                 fifo_full_s, fifo_empty_s, fifo_pop_s, wd_expire_s;

  instr_fifo #(
    .W     (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (fifo_pop_s),
    .din   (wr_instr),
    .dout  (fifo_head_s),
    .count (count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // hlt and watchdog expiry both suppress the pop of that cycle.
  assign wd_expire_s = (cyc_q == WD_LAST);
  assign fifo_pop_s  = (state_q == RUN) && !cpu_hlt && !wd_expire_s && !fifo_empty_s;

  // FSM next-state, issue path, watchdog and statistics.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    cpu_instr_d = NOP_INSTR;
    cpu_mode_d  = 1'b0;
    issue_d     = 1'b0;
    done_d      = done_q;
    timeout_d   = timeout_q;
    underrun_d  = underrun_q;
    issued_d    = issued_q;
    last_pc_d   = last_pc_q;
    overflow_d  = overflow_q | (wr_en & fifo_full_s & ~fifo_pop_s);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          cpu_mode_d = 1'b1;
          cyc_d      = '0;
        end else begin
          state_d    = IDLE;
        end
      end
      RUN: begin
        if (cpu_hlt) begin
          state_d   = HALTED;
          last_pc_d = cpu_pc;
          done_d    = 1'b1;
        end else if (wd_expire_s) begin
          state_d   = TIMEOUT;
          timeout_d = 1'b1;
        end else if (!fifo_empty_s) begin
          cpu_mode_d  = 1'b1;
          cpu_instr_d = fifo_head_s;
          issue_d     = 1'b1;
          issued_d    = sat_inc(issued_q);
          cyc_d       = cyc_q + WD_ONE;
        end else begin
          cpu_mode_d  = 1'b1;
          underrun_d  = sat_inc(underrun_q);
          cyc_d       = cyc_q + WD_ONE;
        end
      end
      HALTED:  state_d = HALTED;
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = IDLE;
    endcase
  end

  // All state and outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      cpu_instr_q <= NOP_INSTR;
      cpu_mode_q  <= 1'b0;
      issue_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= '0;
      issued_q    <= '0;
      last_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      cpu_instr_q <= cpu_instr_d;
      cpu_mode_q  <= cpu_mode_d;
      issue_q     <= issue_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
      issued_q    <= issued_d;
      last_pc_q   <= last_pc_d;
    end
  end

  assign cpu_instr    = cpu_instr_q;
  assign cpu_mode     = cpu_mode_q;
  assign issue        = issue_q;
  assign full         = fifo_full_s;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;
  assign underrun_cnt = underrun_q;
  assign issued_cnt   = issued_q;
  assign last_pc      = last_pc_q;

endmodule

// File: tb/tb_instr_inject_queue.sv
// Directed bench: a default-size instance with a tiny cpu hlt/pc model, and a
// DEPTH=4 / MAX_CYCLES=20 instance for full, overflow and watchdog cases.
module tb_instr_inject_queue;
  import instr_inject_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] pc_base;

  logic        wr_en_a, start_a, cpu_hlt_a, cpu_mode_a, issue_a, full_a;
  logic        done_a, timeout_a, overflow_a;
  logic [15:0] wr_instr_a, cpu_pc_a, cpu_instr_a, underrun_a, issued_a, last_pc_a;
  logic [4:0]  count_a;

  logic        wr_en_b, start_b, cpu_hlt_b, cpu_mode_b, issue_b, full_b;
  logic        done_b, timeout_b, overflow_b;
  logic [15:0] wr_instr_b, cpu_pc_b, cpu_instr_b, underrun_b, issued_b, last_pc_b;
  logic [2:0]  count_b;

  instr_inject_queue u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_instr(wr_instr_a), .start(start_a),
    .cpu_pc(cpu_pc_a), .cpu_hlt(cpu_hlt_a), .cpu_instr(cpu_instr_a), .cpu_mode(cpu_mode_a),
    .issue(issue_a), .full(full_a), .count(count_a), .done(done_a), .timeout(timeout_a),
    .overflow(overflow_a), .underrun_cnt(underrun_a), .issued_cnt(issued_a), .last_pc(last_pc_a)
  );

  instr_inject_queue #(.DEPTH(4), .MAX_CYCLES(20)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_instr(wr_instr_b), .start(start_b),
    .cpu_pc(cpu_pc_b), .cpu_hlt(cpu_hlt_b), .cpu_instr(cpu_instr_b), .cpu_mode(cpu_mode_b),
    .issue(issue_b), .full(full_b), .count(count_b), .done(done_b), .timeout(timeout_b),
    .overflow(overflow_b), .underrun_cnt(underrun_b), .issued_cnt(issued_b), .last_pc(last_pc_b)
  );

  // cpu model: decodes HLT from the presented word, pc tracks the presented instruction
  assign cpu_hlt_a = cpu_mode_a && (cpu_instr_a[15:12] == HLT_OPC);
  assign cpu_hlt_b = 1'b0;
  assign cpu_pc_b  = 16'h0000;

  always @(posedge clk or posedge rst) begin
    if (rst) cpu_pc_a <= pc_base;
    else if (cpu_mode_a && issue_a && !cpu_hlt_a) cpu_pc_a <= cpu_pc_a + 16'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic push_a(input logic [15:0] w);
    wr_en_a = 1'b1; wr_instr_a = w;
    step();
    wr_en_a = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] w);
    wr_en_b = 1'b1; wr_instr_b = w;
    step();
    wr_en_b = 1'b0;
  endtask

  logic [15:0] prog2 [0:4];
  logic [15:0] prog6 [0:6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pc_base = 16'h0000;
    wr_en_a = 1'b0; start_a = 1'b0; wr_instr_a = 16'h0000;
    wr_en_b = 1'b0; start_b = 1'b0; wr_instr_b = 16'h0000;
    step(); step();
    check("rst_cpu_instr", cpu_instr_a, 16'h0000);
    check("rst_count",     count_a, 5'd0);
    check("rst_mode",      cpu_mode_a, 1'b0);
    check("rst_done_b",    {done_b, timeout_b, overflow_b, full_b}, 4'b0000);
    rst = 1'b0;
    step();

    // reset mid-RUN with queued words
    push_a(16'h1111); push_a(16'h2222); push_a(16'h3333);
    start_a = 1'b1; step(); start_a = 1'b0;
    check("t1_mode_run", cpu_mode_a, 1'b1);
    step();
    check("t1_first", cpu_instr_a, 16'h1111);
    check("t1_count2", count_a, 5'd2);
    #2 rst = 1'b1;
    #1;
    check("t1_async_count", count_a, 5'd0);
    check("t1_async_mode",  cpu_mode_a, 1'b0);
    check("t1_async_instr", cpu_instr_a, 16'h0000);
    check("t1_async_cnt",   {issue_a, issued_a}, 17'd0);
    step();
    rst = 1'b0;
    step(); step();
    check("t1_idle_mode", cpu_mode_a, 1'b0);
    check("t1_idle_cnt",  issued_a, 16'd0);

    // straight stream ending in HLT
    prog2 = '{16'hB102, 16'hA100, 16'hB201, 16'hA200, 16'hF000};
    for (int i = 0; i < 5; i++) push_a(prog2[i]);
    check("t2_count5", count_a, 5'd5);
    start_a = 1'b1; step(); start_a = 1'b0;
    check("t2_nop_at_start", cpu_instr_a, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t2_instr%0d", i), cpu_instr_a, prog2[i]);
      check($sformatf("t2_issue%0d", i), issue_a, 1'b1);
    end
    step();
    check("t2_done",     done_a, 1'b1);
    check("t2_issued",   issued_a, 16'd5);
    check("t2_underrun", underrun_a, 16'd0);
    check("t2_nop",      {issue_a, cpu_instr_a}, 17'h00000);
    check("t2_mode",     cpu_mode_a, 1'b0);
    check("t2_last_pc",  last_pc_a, 16'h0004);

    // underrun with late pushes; same-cycle push into empty queue does not bypass
    do_reset();
    push_a(16'hB102);
    start_a = 1'b1; step(); start_a = 1'b0;
    step();
    check("t3_b102", cpu_instr_a, 16'hB102);
    step();
    check("t3_nop1", {issue_a, cpu_instr_a}, 17'h00000);
    step();
    check("t3_nop2", {issue_a, cpu_instr_a}, 17'h00000);
    wr_en_a = 1'b1; wr_instr_a = 16'hA100;
    step();
    check("t3_nop3_nobypass", {issue_a, cpu_instr_a}, 17'h00000);
    check("t3_enq", count_a, 5'd1);
    wr_instr_a = 16'hF000;
    step();
    wr_en_a = 1'b0;
    check("t3_a100", cpu_instr_a, 16'hA100);
    step();
    check("t3_f000", cpu_instr_a, 16'hF000);
    step();
    check("t3_underrun", underrun_a, 16'd3);
    check("t3_done",     done_a, 1'b1);
    check("t3_issued",   issued_a, 16'd3);

    // full / overflow in IDLE on the DEPTH=4 instance
    do_reset();
    push_b(16'h0011); push_b(16'h0022); push_b(16'h0033); push_b(16'h0044);
    check("t4_full",    full_b, 1'b1);
    check("t4_count4",  count_b, 3'd4);
    check("t4_no_ovf",  overflow_b, 1'b0);
    push_b(16'h0055);
    check("t4_ovf",     overflow_b, 1'b1);
    check("t4_count_k", count_b, 3'd4);
    start_b = 1'b1; step(); start_b = 1'b0;
    step(); check("t4_w0", cpu_instr_b, 16'h0011);
    step(); check("t4_w1", cpu_instr_b, 16'h0022);
    step(); check("t4_w2", cpu_instr_b, 16'h0033);
    step(); check("t4_w3", cpu_instr_b, 16'h0044);
    step(); check("t4_dropped", {issue_b, cpu_instr_b}, 17'h00000);
    check("t4_underrun", underrun_b, 16'd1);

    // push+pop while full keeps count; watchdog expires after 20 RUN cycles
    do_reset();
    for (int i = 0; i < 4; i++) push_b(16'h0000);
    start_b = 1'b1; step(); start_b = 1'b0;
    wr_en_b = 1'b1; wr_instr_b = 16'h0000;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 1) begin
        check("t5_pp_count", count_b, 3'd4);
        check("t5_pp_ovf",   overflow_b, 1'b0);
        check("t5_pp_issue", issue_b, 1'b1);
      end
    end
    check("t5_not_yet",  timeout_b, 1'b0);
    check("t5_mode_run", cpu_mode_b, 1'b1);
    step();
    wr_en_b = 1'b0;
    check("t5_timeout", timeout_b, 1'b1);
    check("t5_done0",   done_b, 1'b0);
    check("t5_instr",   {issue_b, cpu_instr_b}, 17'h00000);
    check("t5_issued",  issued_b, 16'd19);
    check("t5_ovf",     overflow_b, 1'b1);
    check("t5_count",   count_b, 3'd4);
    check("t5_mode",    cpu_mode_b, 1'b0);

    // halt with unissued words behind the HLT, pc preset
    pc_base = 16'h0100;
    do_reset();
    prog6 = '{16'h1112, 16'hE500, 16'hC202, 16'hD360, 16'hF000, 16'h0AAA, 16'h0BBB};
    for (int i = 0; i < 7; i++) push_a(prog6[i]);
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t6_hlt_word", cpu_instr_a, 16'hF000);
    step();
    check("t6_done",    done_a, 1'b1);
    check("t6_last_pc", last_pc_a, 16'h0104);
    check("t6_count",   count_a, 5'd2);
    check("t6_issued",  issued_a, 16'd5);
    push_a(16'h0CCC);
    check("t6_no_issue", {issue_a, cpu_instr_a}, 17'h00000);
    check("t6_push_halted", count_a, 5'd3);
    start_a = 1'b1; step(); start_a = 1'b0;
    step();
    check("t6_start_ign", {cpu_mode_a, done_a, issue_a}, 3'b010);
    check("t6_count_k",   count_a, 5'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
